// File: rtl/spi_accel_responder.sv
// ---------------------------------------------------------------------------
// spi_accel_responder
//
// SPI responder (mode 3) that stands in for the board accelerometer. It serves
// the device ID, three control registers and the X/Y/Z sample registers over
// a 4-wire SPI link. SCLK, CSN and SDI are oversampled on clk, so nothing in
// this block is clocked by SCLK.
//
// Build option:
//   ACCEL_INT_EN  when defined, int1 is a data-ready interrupt. It is set one
//                 clk after a shadow update while reg_power_ctl[3]=1. It is
//                 cleared when a read transfers address 0x37. When undefined,
//                 int1 is tied to 0.
//
// Parameters:
//   DEVID        value returned at address 0x00
//   SYNC_STAGES  synchronizer depth on spi_sclk/spi_csn/spi_sdi (>= 2)
//
// Ports:
//   clk, rst                   system clock (>= 8x SCLK), async active-high reset
//   sample_valid, sample_x/y/z new sample strobe and 16-bit two's complement data
//   spi_sclk, spi_csn, spi_sdi SPI inputs from the initiator
//   spi_sdo, spi_sdo_oe        SPI data out and its output enable
//   int1                       data-ready interrupt
//   reg_bw_rate                register 0x2C
//   reg_power_ctl              register 0x2D
//   reg_data_format            register 0x31
//   busy                       high while a transaction is in progress
// ---------------------------------------------------------------------------
module spi_accel_responder #(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  input  logic        spi_sclk,
  input  logic        spi_csn,
  input  logic        spi_sdi,
  output logic        spi_sdo,
  output logic        spi_sdo_oe,
  output logic        int1,
  output logic [7:0]  reg_bw_rate,
  output logic [7:0]  reg_power_ctl,
  output logic [7:0]  reg_data_format,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_READ,
    ST_WRITE
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] csn_sync_q;
  logic [SYNC_STAGES-1:0] sdi_sync_q;
  logic                   sclk_prev_q;
  logic                   csn_prev_q;
  logic [2:0]             bit_cnt_q;
  logic [6:0]             shift_q;
  logic [7:0]             tx_q;
  logic [5:0]             addr_q;
  logic                   mb_q;
  logic                   sdo_q;
  logic                   sdo_oe_q;
  logic [7:0]             bw_q;
  logic [7:0]             pc_q;
  logic [7:0]             df_q;
  logic [15:0]            shx_q, shy_q, shz_q;
  logic                   pend_q;
  logic [15:0]            pdx_q, pdy_q, pdz_q;

  logic       sclk_s, csn_s, sdi_s;
  logic       sclk_rise, sclk_fall, csn_rise, csn_fall;
  logic       byte_done;
  logic       cmd_done, rd_byte_done, wr_byte_done;
  logic [7:0] rx_byte_d;
  logic [5:0] addr_next_d;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign csn_s  = csn_sync_q[SYNC_STAGES-1];
  assign sdi_s  = sdi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign csn_rise  = csn_s & ~csn_prev_q;
  assign csn_fall  = ~csn_s & csn_prev_q;

  // Byte currently being completed: seven earlier bits plus the one arriving now
  assign rx_byte_d = {shift_q, sdi_s};
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);

  // A CSN rise aborts the frame, so a byte completing in the same cycle is dropped
  assign cmd_done     = (state_q == ST_CMD)   && byte_done && !csn_rise;
  assign rd_byte_done = (state_q == ST_READ)  && byte_done && !csn_rise;
  assign wr_byte_done = (state_q == ST_WRITE) && byte_done && !csn_rise;

  // Six-bit add wraps 0x3F -> 0x00 on multi-byte increment
  assign addr_next_d = mb_q ? (addr_q + 6'd1) : addr_q;

  assign busy            = (state_q != ST_IDLE);
  assign spi_sdo         = sdo_q;
  assign spi_sdo_oe      = sdo_oe_q;
  assign reg_bw_rate     = bw_q;
  assign reg_power_ctl   = pc_q;
  assign reg_data_format = df_q;

  function automatic logic [7:0] reg_rd(input logic [5:0] a);
    logic [7:0] v;
    v = 8'h00;
    case (a)
      6'h00: v = DEVID;
      6'h2C: v = bw_q;
      6'h2D: v = pc_q;
      6'h31: v = df_q;
      6'h32: v = shx_q[7:0];
      6'h33: v = shx_q[15:8];
      6'h34: v = shy_q[7:0];
      6'h35: v = shy_q[15:8];
      6'h36: v = shz_q[7:0];
      6'h37: v = shz_q[15:8];
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Input synchronizers; reset to the idle bus levels so no edge is seen on release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '1;
      csn_sync_q  <= '1;
      sdi_sync_q  <= '0;
      sclk_prev_q <= 1'b1;
      csn_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi};
      sclk_prev_q <= sclk_s;
      csn_prev_q  <= csn_s;
    end
  end

  // Transaction FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 7'd0;
      tx_q      <= 8'h00;
      addr_q    <= 6'd0;
      mb_q      <= 1'b0;
      sdo_q     <= 1'b0;
      sdo_oe_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sdo_oe_q <= 1'b0;
          if (csn_fall) begin
            state_q   <= ST_CMD;
            bit_cnt_q <= 3'd0;
          end
        end
        default: begin
          if (csn_rise) begin
            state_q   <= ST_IDLE;
            sdo_oe_q  <= 1'b0;
            sdo_q     <= 1'b0;
            bit_cnt_q <= 3'd0;
          end else begin
            if (sclk_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              shift_q   <= rx_byte_d[6:0];
            end
            if (cmd_done) begin
              mb_q   <= rx_byte_d[6];
              addr_q <= rx_byte_d[5:0];
              if (rx_byte_d[7]) begin
                state_q  <= ST_READ;
                tx_q     <= reg_rd(rx_byte_d[5:0]);
                sdo_oe_q <= 1'b1;
              end else begin
                state_q <= ST_WRITE;
              end
            end
            // Mode 3: responder shifts on the falling edge, initiator samples on the rise
            if ((state_q == ST_READ) && sclk_fall) begin
              sdo_q <= tx_q[7];
              tx_q  <= {tx_q[6:0], 1'b0};
            end
            if (rd_byte_done) begin
              addr_q <= addr_next_d;
              tx_q   <= reg_rd(addr_next_d);
            end
            if (wr_byte_done) begin
              addr_q <= addr_next_d;
            end
          end
        end
      endcase
    end
  end

  // Writable control registers; everything else ignores writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bw_q <= 8'h0A;
      pc_q <= 8'h00;
      df_q <= 8'h00;
    end else if (wr_byte_done) begin
      case (addr_q)
        6'h2C:   bw_q <= rx_byte_d;
        6'h2D:   pc_q <= rx_byte_d;
        6'h31:   df_q <= rx_byte_d;
        default: ;
      endcase
    end
  end

  // Sample shadows are frozen during a frame so a burst always returns one sample;
  // a sample arriving mid-frame waits (newest wins) and lands once the bus is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shx_q  <= 16'd0;
      shy_q  <= 16'd0;
      shz_q  <= 16'd0;
      pend_q <= 1'b0;
      pdx_q  <= 16'd0;
      pdy_q  <= 16'd0;
      pdz_q  <= 16'd0;
    end else if (state_q == ST_IDLE) begin
      if (sample_valid) begin
        shx_q  <= sample_x;
        shy_q  <= sample_y;
        shz_q  <= sample_z;
        pend_q <= 1'b0;
      end else if (pend_q) begin
        shx_q  <= pdx_q;
        shy_q  <= pdy_q;
        shz_q  <= pdz_q;
        pend_q <= 1'b0;
      end
    end else if (sample_valid) begin
      pdx_q  <= sample_x;
      pdy_q  <= sample_y;
      pdz_q  <= sample_z;
      pend_q <= 1'b1;
    end
  end

`ifdef ACCEL_INT_EN
  logic shadow_load_d;
  logic shupd_q;
  logic int1_q;

  assign shadow_load_d = (state_q == ST_IDLE) && (sample_valid || pend_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shupd_q <= 1'b0;
      int1_q  <= 1'b0;
    end else begin
      shupd_q <= shadow_load_d;
      if (shupd_q && pc_q[3]) begin
        int1_q <= 1'b1;
      end else if (rd_byte_done && (addr_q == 6'h37)) begin
        int1_q <= 1'b0;
      end
    end
  end

  assign int1 = int1_q;
`else
  assign int1 = 1'b0;
`endif

endmodule

// File: tb/tb_spi_accel_responder.sv
// ---------------------------------------------------------------------------
// Testbench for spi_accel_responder. A mode-3 SPI initiator is driven from
// one initial block; expected values come from a register-table model
// (64-entry array) updated from the register map rules.
// ---------------------------------------------------------------------------
module tb_spi_accel_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [15:0] sample_x, sample_y, sample_z;
  logic        spi_sclk, spi_csn, spi_sdi;
  logic        spi_sdo, spi_sdo_oe, int1, busy;
  logic [7:0]  reg_bw_rate, reg_power_ctl, reg_data_format;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] m_reg [64];
  logic [7:0] tx_buf [8];
  logic [7:0] rx_buf [8];
  logic       oe_cmd, oe_data_all, busy_mid;

  always #5 clk = ~clk;

  spi_accel_responder dut (
    .clk             (clk),
    .rst             (rst),
    .sample_valid    (sample_valid),
    .sample_x        (sample_x),
    .sample_y        (sample_y),
    .sample_z        (sample_z),
    .spi_sclk        (spi_sclk),
    .spi_csn         (spi_csn),
    .spi_sdi         (spi_sdi),
    .spi_sdo         (spi_sdo),
    .spi_sdo_oe      (spi_sdo_oe),
    .int1            (int1),
    .reg_bw_rate     (reg_bw_rate),
    .reg_power_ctl   (reg_power_ctl),
    .reg_data_format (reg_data_format),
    .busy            (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic m_reset();
    for (int i = 0; i < 64; i++) m_reg[i] = 8'h00;
    m_reg[6'h00] = 8'hE5;
    m_reg[6'h2C] = 8'h0A;
  endtask

  task automatic m_write(input logic [5:0] a, input logic [7:0] d);
    if (a == 6'h2C || a == 6'h2D || a == 6'h31) m_reg[a] = d;
  endtask

  task automatic m_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    m_reg[6'h32] = x[7:0];  m_reg[6'h33] = x[15:8];
    m_reg[6'h34] = y[7:0];  m_reg[6'h35] = y[15:8];
    m_reg[6'h36] = z[7:0];  m_reg[6'h37] = z[15:8];
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".bw"}, {24'd0, reg_bw_rate},     {24'd0, m_reg[6'h2C]});
    check({tag, ".pc"}, {24'd0, reg_power_ctl},   {24'd0, m_reg[6'h2D]});
    check({tag, ".df"}, {24'd0, reg_data_format}, {24'd0, m_reg[6'h31]});
  endtask

  // ---------------- SPI initiator ----------------
  task automatic spi_bit(input logic b, output logic so, output logic oe);
    spi_sclk = 1'b0;
    spi_sdi  = b;
    repeat (4) @(negedge clk);
    so = spi_sdo;
    oe = spi_sdo_oe;
    spi_sclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk);
    sample_x = x; sample_y = y; sample_z = z;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // One frame: command byte, nbytes data bytes (last one cut to last_bits),
  // optional sample pulse before data byte sv_byte.
  task automatic frame(input logic [7:0] cmd, input int nbytes, input int sv_byte,
                       input int last_bits, input logic [15:0] sx, input logic [15:0] sy,
                       input logic [15:0] sz);
    logic so, oe;
    int nb;
    spi_csn = 1'b0;
    repeat (4) @(negedge clk);
    oe_cmd = 1'b0;
    oe_data_all = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(cmd[i], so, oe);
      if (oe) oe_cmd = 1'b1;
    end
    busy_mid = busy;
    for (int k = 0; k < nbytes; k++) begin
      if (k == sv_byte) pulse_sample(sx, sy, sz);
      nb = (k == nbytes - 1) ? last_bits : 8;
      rx_buf[k] = 8'h00;
      for (int j = 0; j < nb; j++) begin
        spi_bit(tx_buf[k][7-j], so, oe);
        rx_buf[k][7-j] = so;
        if (!oe) oe_data_all = 1'b0;
      end
    end
    repeat (4) @(negedge clk);
    spi_csn = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Read burst checked byte-by-byte against the model
  task automatic read_chk(input string tag, input logic [5:0] a, input logic mb, input int n);
    logic [5:0] aa;
    frame({1'b1, mb, a}, n, -1, 8, 16'd0, 16'd0, 16'd0);
    aa = a;
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s.rd%0d@%0h", tag, k, aa), {24'd0, rx_buf[k]}, {24'd0, m_reg[aa]});
      if (mb) aa = aa + 6'd1;
    end
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  alist [9];
    logic [5:0]  a6, aa;
    logic        mb;
    int          n, op;
    logic [15:0] rx, ry, rz;
    logic        so, oe;

    alist = '{6'h00, 6'h2C, 6'h2D, 6'h31, 6'h32, 6'h35, 6'h37, 6'h3F, 6'h10};
    rst = 1'b1;
    sample_valid = 1'b0;
    sample_x = '0; sample_y = '0; sample_z = '0;
    spi_sclk = 1'b1; spi_csn = 1'b1; spi_sdi = 1'b0;
    for (int i = 0; i < 8; i++) tx_buf[i] = 8'h00;
    m_reset();
    repeat (3) @(negedge clk);

    // Reset state
    check("rst.sdo", {31'd0, spi_sdo}, 32'd0);
    check("rst.oe", {31'd0, spi_sdo_oe}, 32'd0);
    check("rst.int1", {31'd0, int1}, 32'd0);
    check("rst.busy", {31'd0, busy}, 32'd0);
    check_regs("rst");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // DEVID read, output enable only during the data byte
    frame(8'h80, 1, -1, 8, 16'd0, 16'd0, 16'd0);
    check("devid", {24'd0, rx_buf[0]}, 32'hE5);
    check("devid.oe_cmd", {31'd0, oe_cmd}, 32'd0);
    check("devid.oe_data", {31'd0, oe_data_all}, 32'd1);
    check("devid.busy_mid", {31'd0, busy_mid}, 32'd1);
    check("devid.oe_after", {31'd0, spi_sdo_oe}, 32'd0);
    check("devid.busy_after", {31'd0, busy}, 32'd0);

    // Sample burst read
    pulse_sample(16'h1234, 16'hFFEE, 16'h0100);
    repeat (2) @(negedge clk);
    m_sample(16'h1234, 16'hFFEE, 16'h0100);
    frame(8'hF2, 6, -1, 8, 16'd0, 16'd0, 16'd0);
    check("burst.b0", {24'd0, rx_buf[0]}, 32'h34);
    check("burst.b1", {24'd0, rx_buf[1]}, 32'h12);
    check("burst.b2", {24'd0, rx_buf[2]}, 32'hEE);
    check("burst.b3", {24'd0, rx_buf[3]}, 32'hFF);
    check("burst.b4", {24'd0, rx_buf[4]}, 32'h00);
    check("burst.b5", {24'd0, rx_buf[5]}, 32'h01);

    // Writes: control register and read-only DEVID
    tx_buf[0] = 8'h08;
    frame(8'h2D, 1, -1, 8, 16'd0, 16'd0, 16'd0);
    m_write(6'h2D, 8'h08);
    check("wr.pc", {24'd0, reg_power_ctl}, 32'h08);
    read_chk("rdpc", 6'h2D, 1'b0, 1);
    tx_buf[0] = 8'h55;
    frame(8'h00, 1, -1, 8, 16'd0, 16'd0, 16'd0);
    read_chk("ro", 6'h00, 1'b0, 1);

    // Aborted write after 4 data bits
    tx_buf[0] = 8'h77;
    frame(8'h2C, 1, -1, 4, 16'd0, 16'd0, 16'd0);
    check("abort.bw", {24'd0, reg_bw_rate}, 32'h0A);
    check("abort.busy", {31'd0, busy}, 32'd0);
    read_chk("abort.next", 6'h2C, 1'b0, 2);

    // Sample arriving mid-burst is held until the frame ends
    tx_buf[0] = 8'h00;
    frame(8'hF2, 6, 2, 8, 16'hAAAA, 16'h5A5A, 16'hC3C3);
    aa = 6'h32;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("midburst.b%0d", k), {24'd0, rx_buf[k]}, {24'd0, m_reg[aa]});
      aa = aa + 6'd1;
    end
    m_sample(16'hAAAA, 16'h5A5A, 16'hC3C3);
    read_chk("after_mid", 6'h32, 1'b1, 2);

`ifdef ACCEL_INT_EN
    check("int.set_pending", {31'd0, int1}, 32'd1);
    read_chk("int.clr", 6'h32, 1'b1, 6);
    check("int.cleared", {31'd0, int1}, 32'd0);
`else
    check("int.tied", {31'd0, int1}, 32'd0);
`endif

    // Reset in the middle of a read
    pulse_sample(16'h0102, 16'h0304, 16'h0506);
    repeat (3) @(negedge clk);
    m_sample(16'h0102, 16'h0304, 16'h0506);
`ifdef ACCEL_INT_EN
    check("int.set", {31'd0, int1}, 32'd1);
`endif
    spi_csn = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 7; i >= 0; i--) spi_bit(i == 7, so, oe);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, so, oe);
    check("midrst.oe_before", {31'd0, spi_sdo_oe}, 32'd1);
    check("midrst.busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    m_reset();
    check("midrst.oe", {31'd0, spi_sdo_oe}, 32'd0);
    check("midrst.int1", {31'd0, int1}, 32'd0);
    check("midrst.busy", {31'd0, busy}, 32'd0);
    check_regs("midrst");
    spi_csn = 1'b1;
    spi_sclk = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Address wrap 0x3F -> 0x00 in a multi-byte read
    read_chk("wrap", 6'h3F, 1'b1, 2);
    check("wrap.devid", {24'd0, rx_buf[1]}, 32'hE5);

    // Randomized transactions against the model
    for (int it = 0; it < 25; it++) begin
      op = $urandom_range(0, 2);
      a6 = alist[$urandom_range(0, 8)];
      mb = 1'($urandom_range(0, 1));
      if (op == 0) begin
        n = $urandom_range(1, 2);
        for (int k = 0; k < n; k++) tx_buf[k] = 8'($urandom);
        frame({1'b0, mb, a6}, n, -1, 8, 16'd0, 16'd0, 16'd0);
        aa = a6;
        for (int k = 0; k < n; k++) begin
          m_write(aa, tx_buf[k]);
          if (mb) aa = aa + 6'd1;
        end
      end else if (op == 1) begin
        n = $urandom_range(1, 3);
        read_chk($sformatf("rnd%0d", it), a6, mb, n);
      end else begin
        rx = 16'($urandom); ry = 16'($urandom); rz = 16'($urandom);
        pulse_sample(rx, ry, rz);
        repeat (2) @(negedge clk);
        m_sample(rx, ry, rz);
      end
      check_regs($sformatf("rnd%0d", it));
    end
    read_chk("final", 6'h32, 1'b1, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
